// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the pipeline and muldiv_unit.
//   start   - operation request
//   alu_ctl - decoder ALU code (00010..01001 are RV32M ops)
//   op_a    - rs1 value
//   op_b    - rs2 value
//   flush   - abort in-flight operation
//   busy    - unit is computing (CALC or FIX)
//   done    - one-cycle completion pulse
//   result  - final value, held until next accept or reset
// master: pipeline side; slave: muldiv_unit side.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [4:0]      alu_ctl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, alu_ctl, op_a, op_b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, alu_ctl, op_a, op_b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M execute unit.
//   Iterative shift-add multiplier (MUL/MULH/MULHSU/MULHU) and restoring
//   divider (DIV/DIVU/REM/REMU), one iteration per cycle for 32 cycles,
//   followed by one FIX cycle for sign correction and special cases.
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous reset, active-high
//   bus - muldiv_unit_if.slave (start/alu_ctl/op_a/op_b/flush in,
//         busy/done/result out)
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [4:0] OP_MUL    = 5'b00010;
    localparam logic [4:0] OP_MULH   = 5'b00011;
    localparam logic [4:0] OP_MULHSU = 5'b00100;
    localparam logic [4:0] OP_MULHU  = 5'b00101;
    localparam logic [4:0] OP_DIV    = 5'b00110;
    localparam logic [4:0] OP_DIVU   = 5'b00111;
    localparam logic [4:0] OP_REM    = 5'b01000;
    localparam logic [4:0] OP_REMU   = 5'b01001;

    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    logic [1:0]        state;
    logic [4:0]        cnt;
    logic [4:0]        op_q;
    logic              sa, sb;
    logic [XLEN-1:0]   a_raw, b_raw;
    logic [2*XLEN-1:0] acc;      // product accumulator
    logic [2*XLEN-1:0] mcand;    // multiplicand, shifted left each step
    logic [XLEN-1:0]   mplier;   // multiplier (shifted right) or divisor
    logic [XLEN-1:0]   dq;       // dividend bits shifting out, quotient shifting in
    logic [XLEN-1:0]   rem;      // partial remainder
    logic [XLEN-1:0]   result_q;

    // Request decode
    logic            op_ok, accept, a_signed, b_signed, neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        op_ok    = (bus.alu_ctl >= OP_MUL) && (bus.alu_ctl <= OP_REMU);
        accept   = bus.start && op_ok && !bus.flush &&
                   ((state == S_IDLE) || (state == S_DONE));
        a_signed = (bus.alu_ctl == OP_MULH) || (bus.alu_ctl == OP_MULHSU) ||
                   (bus.alu_ctl == OP_DIV)  || (bus.alu_ctl == OP_REM);
        b_signed = (bus.alu_ctl == OP_MULH) || (bus.alu_ctl == OP_DIV) ||
                   (bus.alu_ctl == OP_REM);
        neg_a    = a_signed && bus.op_a[XLEN-1];
        neg_b    = b_signed && bus.op_b[XLEN-1];
        mag_a    = neg_a ? -bus.op_a : bus.op_a;
        mag_b    = neg_b ? -bus.op_b : bus.op_b;
    end

    // Restoring divide step. A shifted value with bit 32 set always exceeds
    // the divisor, so the 32-bit difference is exact whenever it is taken.
    logic            is_div;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            q_bit;

    always_comb begin
        is_div  = (op_q >= OP_DIV);
        shifted = {rem, dq[XLEN-1]};
        diff    = shifted[XLEN-1:0] - mplier;
        q_bit   = (shifted >= {1'b0, mplier});
    end

    // Sign correction and special-case override (FIX cycle)
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, remv, fix_val;

    always_comb begin
        prod    = (sa ^ sb) ? -acc : acc;
        quot    = (sa ^ sb) ? -dq  : dq;
        remv    = sa ? -rem : rem;
        fix_val = '0;
        case (op_q)
            OP_MUL:                         fix_val = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   fix_val = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                fix_val = quot;
            OP_REM, OP_REMU:                fix_val = remv;
            default:                        fix_val = '0;
        endcase
        if (is_div && (b_raw == '0)) begin
            fix_val = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? '1 : a_raw;
        end else if (((op_q == OP_DIV) || (op_q == OP_REM)) &&
                     (a_raw == {1'b1, {(XLEN-1){1'b0}}}) && (b_raw == '1)) begin
            fix_val = (op_q == OP_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            a_raw    <= '0;
            b_raw    <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            dq       <= '0;
            rem      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state  <= S_CALC;
                        cnt    <= '0;
                        op_q   <= bus.alu_ctl;
                        sa     <= neg_a;
                        sb     <= neg_b;
                        a_raw  <= bus.op_a;
                        b_raw  <= bus.op_b;
                        acc    <= '0;
                        mcand  <= {{XLEN{1'b0}}, mag_a};
                        mplier <= mag_b;
                        dq     <= mag_a;
                        rem    <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (is_div) begin
                            rem <= q_bit ? diff : shifted[XLEN-1:0];
                            dq  <= {dq[XLEN-2:0], q_bit};
                        end else begin
                            if (mplier[0]) acc <= acc + mcand;
                            mcand  <= mcand << 1;
                            mplier <= mplier >> 1;
                        end
                        cnt <= cnt + 5'd1;
                        if (cnt == LAST_ITER) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else begin
                        result_q <= fix_val;
                        state    <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy   = (state == S_CALC) || (state == S_FIX);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge. Cycle 1 is the first falling edge after the accepting rising edge.
module tb_muldiv_unit;

    localparam logic [4:0] MUL = 5'b00010, MULH = 5'b00011, MULHSU = 5'b00100,
                           MULHU = 5'b00101, DIV = 5'b00110, DIVU = 5'b00111,
                           REM = 5'b01000, REMU = 5'b01001;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Issue one operation and wait (bounded) for done.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int bcnt);
        @(negedge clk);
        bus.start = 1'b1; bus.alu_ctl = op; bus.op_a = a; bus.op_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1; bcnt = 0; res = 'x;
        for (int i = 1; i <= 60; i++) begin
            if (i > 1) @(negedge clk);
            if (bus.busy) bcnt++;
            if (bus.done) begin
                lat = i;
                res = bus.result;
                break;
            end
        end
        if (lat < 0) $display("FAIL op_timeout: op %b got no done within 60 cycles, required done at 34", op);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.alu_ctl = '0; bus.op_a = '0; bus.op_b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
            $display("FAIL reset_state: busy=%b done=%b result=%h, required 0 0 00000000",
                     bus.busy, bus.done, bus.result);
            errors++;
        end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        logic [31:0] res; int lat, bcnt;
        run_op(MUL, 32'd7, 32'hFFFFFFFD, res, lat, bcnt);
        checks++;
        if (res !== 32'hFFFFFFEB) begin
            $display("FAIL mul_result: got %h required FFFFFFEB", res); errors++;
        end
        checks++;
        if (lat !== 34) begin
            $display("FAIL mul_latency: got %0d required 34", lat); errors++;
        end
        checks++;
        if (bcnt !== 33) begin
            $display("FAIL mul_busy_cycles: got %0d required 33", bcnt); errors++;
        end
    endtask

    // Shared vector table for the high-multiply, divide and special-case tests
    task automatic test_vectors(input string name, input logic [4:0] ops[],
                                input logic [31:0] as[], input logic [31:0] bs[],
                                input logic [31:0] exps[]);
        logic [31:0] res; int lat, bcnt;
        for (int i = 0; i < ops.size(); i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, bcnt);
            checks++;
            if (res !== exps[i]) begin
                $display("FAIL %s[%0d]_result: op %b %h,%h got %h required %h",
                         name, i, ops[i], as[i], bs[i], res, exps[i]);
                errors++;
            end
            checks++;
            if (lat !== 34) begin
                $display("FAIL %s[%0d]_latency: got %0d required 34", name, i, lat); errors++;
            end
        end
    endtask

    task automatic test_mulh();
        test_vectors("mulh", '{MULH, MULHU, MULHSU},
                     '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF},
                     '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF},
                     '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF});
    endtask

    task automatic test_div();
        test_vectors("div", '{DIV, REM, DIVU, REMU},
                     '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100},
                     '{32'd2, 32'd2, 32'd7, 32'd7},
                     '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2});
    endtask

    task automatic test_special();
        test_vectors("special", '{DIVU, REMU, DIV, DIV, REM, REM},
                     '{32'd100, 32'd100, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFFB},
                     '{32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0},
                     '{32'hFFFFFFFF, 32'd100, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'hFFFFFFFB});
    endtask

    task automatic test_flush_illegal();
        logic [31:0] res; int lat, bcnt; int seen_done, seen_busy;
        run_op(DIVU, 32'd100, 32'd7, res, lat, bcnt);   // prior result = 14
        @(negedge clk);
        bus.start = 1'b1; bus.alu_ctl = DIV; bus.op_a = 32'd1000; bus.op_b = 32'd3;
        @(negedge clk);                                  // cycle 1, counter 0
        bus.start = 1'b0;
        repeat (10) @(negedge clk);                      // cycle 11, counter 10
        checks++;
        if (bus.busy !== 1'b1) begin
            $display("FAIL flush_pre_busy: got %b required 1", bus.busy); errors++;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            $display("FAIL flush_abort: busy=%b done=%b required 0 0", bus.busy, bus.done); errors++;
        end
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            $display("FAIL flush_no_done: got %0d done cycles required 0", seen_done); errors++;
        end
        checks++;
        if (bus.result !== 32'd14) begin
            $display("FAIL flush_result_held: got %h required 0000000e", bus.result); errors++;
        end
        // Illegal alu_ctl
        bus.start = 1'b1; bus.alu_ctl = 5'b00000; bus.op_a = 32'd9; bus.op_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        seen_done = 0; seen_busy = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy) seen_busy++;
            if (bus.done) seen_done++;
            @(negedge clk);
        end
        checks++;
        if (seen_busy !== 0 || seen_done !== 0) begin
            $display("FAIL illegal_op_ignored: busy cycles %0d done cycles %0d required 0 0",
                     seen_busy, seen_done);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res; int lat, bcnt;
        run_op(MUL, 32'd3, 32'd5, res, lat, bcnt);
        checks++;
        if (res !== 32'd15) begin
            $display("FAIL b2b_first_result: got %h required 0000000f", res); errors++;
        end
        // Now in the DONE cycle: issue the next request immediately
        bus.start = 1'b1; bus.alu_ctl = MUL; bus.op_a = 32'd6; bus.op_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            $display("FAIL b2b_accept: busy=%b done=%b required 1 0", bus.busy, bus.done); errors++;
        end
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            if (i > 1) @(negedge clk);
            if (bus.done) begin lat = i; res = bus.result; break; end
        end
        checks++;
        if (lat !== 34 || res !== 32'd42) begin
            $display("FAIL b2b_second: latency %0d result %h required 34 0000002a", lat, res); errors++;
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            $display("FAIL b2b_done_pulse: done=%b in cycle after done, required 0", bus.done); errors++;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.start = 1'b1; bus.alu_ctl = DIVU; bus.op_a = 32'd50; bus.op_b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
            $display("FAIL reset_mid_calc: busy=%b done=%b result=%h required 0 0 00000000",
                     bus.busy, bus.done, bus.result);
            errors++;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_flush_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
